craps_ctrl: RTL and testbench

CRAPS_CTRL -- requirements
Module: craps_ctrl

---
 rtl/craps_ctrl.sv | 145 ++++++++++++++
 tb/tb_craps_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/craps_ctrl.sv
// Craps game controller: sequences two dice roll stages, evaluates come-out
// and point-phase rolls, and holds the win/lose verdict until a new game.
module craps_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] num_a,
  input  logic       choose_a,
  input  logic [2:0] num_b,
  input  logic       choose_b,
  input  logic       new_game,
  output logic       enable,
  output logic [3:0] sum,
  output logic [3:0] point,
  output logic       point_valid,
  output logic       win,
  output logic       lose,
  output logic [7:0] rolls
);

  typedef enum logic [2:0] {
    ARM  = 3'd0,
    ROLL = 3'd1,
    EVAL = 3'd2,
    WIN  = 3'd3,
    LOSE = 3'd4
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic       enable_s;
  logic [3:0] sum_s;
  logic [3:0] point_s;
  logic       point_valid_s;
  logic       win_s;
  logic       lose_s;
  logic [7:0] rolls_s;
  logic       accept_s;

  function automatic logic face_valid(input logic [2:0] face);
    face_valid = (face != 3'd0) && (face != 3'd7);
  endfunction

  assign accept_s = choose_a & choose_b & face_valid(num_a) & face_valid(num_b);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_s       = state_r;
    enable_s      = 1'b0;
    sum_s         = sum;
    point_s       = point;
    point_valid_s = point_valid;
    win_s         = win;
    lose_s        = lose;
    rolls_s       = rolls;
    case (state_r)
      ARM: begin
        state_s  = ROLL;
        enable_s = 1'b1;
      end
      ROLL: begin
        enable_s = 1'b1;
        if (accept_s) begin
          state_s = EVAL;
          sum_s   = {1'b0, num_a} + {1'b0, num_b};
          rolls_s = (rolls == 8'hFF) ? rolls : rolls + 8'd1;
        end else begin
          state_s = ROLL;
        end
      end
      EVAL: begin
        // Every outcome drops enable so the next roll sees a fresh rising edge.
        enable_s = 1'b0;
        if (!point_valid) begin
          if ((sum == 4'd7) || (sum == 4'd11)) begin
            state_s = WIN;
            win_s   = 1'b1;
          end else if ((sum == 4'd2) || (sum == 4'd3) || (sum == 4'd12)) begin
            state_s = LOSE;
            lose_s  = 1'b1;
          end else begin
            state_s       = ARM;
            point_s       = sum;
            point_valid_s = 1'b1;
          end
        end else begin
          if (sum == point) begin
            state_s = WIN;
            win_s   = 1'b1;
          end else if (sum == 4'd7) begin
            state_s = LOSE;
            lose_s  = 1'b1;
          end else begin
            state_s = ARM;
          end
        end
      end
      WIN, LOSE: begin
        if (new_game) begin
          state_s       = ARM;
          sum_s         = 4'd0;
          point_s       = 4'd0;
          point_valid_s = 1'b0;
          win_s         = 1'b0;
          lose_s        = 1'b0;
          rolls_s       = 8'd0;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s       = ARM;
        sum_s         = 4'd0;
        point_s       = 4'd0;
        point_valid_s = 1'b0;
        win_s         = 1'b0;
        lose_s        = 1'b0;
        rolls_s       = 8'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ARM;
      enable      <= 1'b0;
      sum         <= 4'd0;
      point       <= 4'd0;
      point_valid <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
      rolls       <= 8'd0;
    end else begin
      state_r     <= state_s;
      enable      <= enable_s;
      sum         <= sum_s;
      point       <= point_s;
      point_valid <= point_valid_s;
      win         <= win_s;
      lose        <= lose_s;
      rolls       <= rolls_s;
    end
  end

endmodule

// File: tb/tb_craps_ctrl.sv
// Self-checking bench for craps_ctrl: table of rolls with expected outcomes
// pushed to a scoreboard queue, plus hand sequences for rejection and reset.
module tb_craps_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] num_a = 3'd0;
  logic       choose_a = 1'b0;
  logic [2:0] num_b = 3'd0;
  logic       choose_b = 1'b0;
  logic       new_game = 1'b0;
  logic       enable;
  logic [3:0] sum;
  logic [3:0] point;
  logic       point_valid;
  logic       win;
  logic       lose;
  logic [7:0] rolls;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] sum;
    logic [3:0] point;
    logic       pv;
    logic       win;
    logic       lose;
    logic [7:0] rolls;
    logic       ng;
  } vec_t;

  vec_t vecs [0:13];
  vec_t sb [$];

  craps_ctrl dut (
    .clk(clk), .rst_n(rst_n), .num_a(num_a), .choose_a(choose_a),
    .num_b(num_b), .choose_b(choose_b), .new_game(new_game),
    .enable(enable), .sum(sum), .point(point), .point_valid(point_valid),
    .win(win), .lose(lose), .rolls(rolls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic en, input logic [3:0] s,
                         input logic [3:0] p, input logic pv, input logic w,
                         input logic l, input logic [7:0] r);
    chk({tag, "_enable"}, {7'd0, enable}, {7'd0, en});
    chk({tag, "_sum"}, {4'd0, sum}, {4'd0, s});
    chk({tag, "_point"}, {4'd0, point}, {4'd0, p});
    chk({tag, "_pv"}, {7'd0, point_valid}, {7'd0, pv});
    chk({tag, "_win"}, {7'd0, win}, {7'd0, w});
    chk({tag, "_lose"}, {7'd0, lose}, {7'd0, l});
    chk({tag, "_rolls"}, rolls, r);
  endtask

  task automatic wait_enable(input string tag);
    int k = 0;
    while (enable !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({tag, "_wait_enable"}, {7'd0, enable}, 8'd1);
  endtask

  // Accept one roll, check sum at N+1 and the verdict at N+2 from the scoreboard.
  task automatic do_roll(input vec_t v, input int idx);
    vec_t  e;
    string tag;
    tag = $sformatf("vec%0d", idx);
    wait_enable(tag);
    num_a = v.a; num_b = v.b; choose_a = 1'b1; choose_b = 1'b1;
    sb.push_back(v);
    tick();
    choose_a = 1'b0; choose_b = 1'b0; num_a = 3'd0; num_b = 3'd0;
    chk({tag, "_n1_sum"}, {4'd0, sum}, {4'd0, v.sum});
    chk({tag, "_n1_enable"}, {7'd0, enable}, 8'd1);
    chk({tag, "_n1_rolls"}, rolls, v.rolls);
    tick();
    e = sb.pop_front();
    chk_all({tag, "_n2"}, 1'b0, e.sum, e.point, e.pv, e.win, e.lose, e.rolls);
    chk({tag, "_exclusive"}, {7'd0, win & lose}, 8'd0);
    if (!e.win && !e.lose) begin
      tick();
      chk({tag, "_rearm_enable"}, {7'd0, enable}, 8'd1);
    end
  endtask

  // Verdict must hold while idle, then new_game returns to ARM cleared.
  task automatic do_new_game(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("ng%0d", idx);
    tick();
    tick();
    chk_all({tag, "_hold"}, 1'b0, v.sum, v.point, v.pv, v.win, v.lose, v.rolls);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    chk_all({tag, "_clear"}, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    chk({tag, "_roll_enable"}, {7'd0, enable}, 8'd1);
  endtask

  initial begin
    logic [2:0] bad_a [0:5];
    logic [2:0] bad_b [0:5];
    vec_t v;

    vecs[0]  = '{3'd3, 3'd4, 4'd7,  4'd0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1};
    vecs[1]  = '{3'd1, 3'd1, 4'd2,  4'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1};
    vecs[2]  = '{3'd6, 3'd6, 4'd12, 4'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1};
    vecs[3]  = '{3'd2, 3'd2, 4'd4,  4'd4, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[4]  = '{3'd3, 3'd5, 4'd8,  4'd4, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0};
    vecs[5]  = '{3'd1, 3'd3, 4'd4,  4'd4, 1'b1, 1'b1, 1'b0, 8'd3, 1'b1};
    vecs[6]  = '{3'd2, 3'd2, 4'd4,  4'd4, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[7]  = '{3'd5, 3'd2, 4'd7,  4'd4, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1};
    vecs[8]  = '{3'd5, 3'd6, 4'd11, 4'd0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1};
    vecs[9]  = '{3'd4, 3'd5, 4'd9,  4'd9, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    vecs[10] = '{3'd1, 3'd1, 4'd2,  4'd9, 1'b1, 1'b0, 1'b0, 8'd2, 1'b0};
    vecs[11] = '{3'd1, 3'd2, 4'd3,  4'd9, 1'b1, 1'b0, 1'b0, 8'd3, 1'b0};
    vecs[12] = '{3'd2, 3'd2, 4'd4,  4'd9, 1'b1, 1'b0, 1'b0, 8'd4, 1'b0};
    vecs[13] = '{3'd3, 3'd3, 4'd6,  4'd9, 1'b1, 1'b0, 1'b0, 8'd5, 1'b0};
    bad_a[0] = 3'd0; bad_b[0] = 3'd3;
    bad_a[1] = 3'd7; bad_b[1] = 3'd2;
    bad_a[2] = 3'd4; bad_b[2] = 3'd0;
    bad_a[3] = 3'd5; bad_b[3] = 3'd7;
    bad_a[4] = 3'd0; bad_b[4] = 3'd0;
    bad_a[5] = 3'd7; bad_b[5] = 3'd7;

    // Reset, then exactly one ARM cycle before ROLL.
    rst_n = 1'b0;
    tick();
    tick();
    chk_all("reset", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    chk({"reset_arm", "_enable"}, {7'd0, enable}, 8'd0);
    tick();
    chk("reset_then_roll_enable", {7'd0, enable}, 8'd1);

    for (int i = 0; i <= 8; i++) begin
      do_roll(vecs[i], i);
      if (vecs[i].ng) do_new_game(vecs[i], i);
    end

    // Partial or invalid accepts must leave the FSM in ROLL.
    num_a = 3'd3; num_b = 3'd4; choose_a = 1'b1; choose_b = 1'b0;
    repeat (10) tick();
    chk_all("choose_a_only", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    choose_a = 1'b0; choose_b = 1'b1;
    repeat (3) tick();
    chk_all("choose_b_only", 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      num_a = bad_a[i]; num_b = bad_b[i]; choose_a = 1'b1; choose_b = 1'b1;
      tick();
      choose_a = 1'b0; choose_b = 1'b0;
      tick();
      chk_all($sformatf("bad_face%0d", i), 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    end
    num_a = 3'd0; num_b = 3'd0;

    // new_game ignored in ROLL during point phase, honoured in WIN.
    v = '{3'd2, 3'd2, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0};
    do_roll(v, 20);
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tick();
    chk_all("ng_in_roll", 1'b1, 4'd4, 4'd4, 1'b1, 1'b0, 1'b0, 8'd1);
    v = '{3'd1, 3'd3, 4'd4, 4'd4, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1};
    do_roll(v, 21);
    do_new_game(v, 21);

    for (int i = 9; i <= 13; i++) begin
      do_roll(vecs[i], i);
    end

    // One-cycle reset in point phase with point 9 and five rolls.
    chk_all("pre_reset", 1'b1, 4'd6, 4'd9, 1'b1, 1'b0, 1'b0, 8'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_all("mid_reset", 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick();
    chk("mid_reset_roll_enable", {7'd0, enable}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
